// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic constants and the coefficient type for the NTT datapath.
package kyber_pkg;

    localparam int KYBER_Q   = 3329;
    localparam int BARRETT_V = 20159;
    localparam int MONT      = -1044;  // 2^16 mod q, centred
    localparam int QINV      = -3327;  // q^-1 mod 2^16, signed

    typedef logic signed [15:0] coeff_t;

endpackage

// File: rtl/ntt_bf_post_if.sv
// Controller-side bus of the butterfly post stage: issue side-band, Montgomery result, write-back pair.
interface ntt_bf_post_if #(
    parameter int ADDR_W = 8
);
    import kyber_pkg::*;

    logic              issue_valid;
    coeff_t            r_j;
    logic [ADDR_W-1:0] addr_j;
    logic [ADDR_W-1:0] addr_k;
    coeff_t            mont_t;
    logic              out_valid;
    coeff_t            out_lo;
    coeff_t            out_hi;
    logic [ADDR_W-1:0] out_addr_j;
    logic [ADDR_W-1:0] out_addr_k;
    logic              layer_done;
    logic [7:0]        bf_count;

    modport master (
        output issue_valid, r_j, addr_j, addr_k, mont_t,
        input  out_valid, out_lo, out_hi, out_addr_j, out_addr_k, layer_done, bf_count
    );

    modport slave (
        input  issue_valid, r_j, addr_j, addr_k, mont_t,
        output out_valid, out_lo, out_hi, out_addr_j, out_addr_k, layer_done, bf_count
    );

endinterface

// File: rtl/ntt_bf_post_barrett_reduce.sv
// One registered Barrett reduction stage; output is centred in [-(q-1)/2, (q-1)/2].
module barrett_reduce
    import kyber_pkg::*;
#(
    parameter int Q = kyber_pkg::KYBER_Q,
    parameter int V = kyber_pkg::BARRETT_V
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  coeff_t x,
    output coeff_t y
);

    logic signed [31:0] xs;
    logic signed [31:0] prod;
    logic signed [31:0] qest;
    coeff_t             yn;

    always_comb begin
        xs   = 32'(x);
        prod = xs * 32'(V);
        // Adding 2^25 before the arithmetic shift rounds q_est to nearest.
        qest = (prod + 32'sd33554432) >>> 26;
        yn   = 16'(xs - qest * 32'(Q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y <= '0;
        end else if (en) begin
            y <= yn;
        end
    end

endmodule

// File: rtl/ntt_bf_post.sv
// NTT butterfly post stage: aligns r_j/addresses with the Montgomery product, adds/subtracts, Barrett-reduces, counts layers.
module ntt_bf_post
    import kyber_pkg::*;
#(
    parameter int KYBER_Q      = kyber_pkg::KYBER_Q,
    parameter int BARRETT_V    = kyber_pkg::BARRETT_V,
    parameter int MONT_LAT     = 2,
    parameter int ADDR_W       = 8,
    parameter int BF_PER_LAYER = 128
) (
    input logic              clk,
    input logic              rst,
    ntt_bf_post_if.slave     bus
);

    logic              al_v  [MONT_LAT];
    coeff_t            al_r  [MONT_LAT];
    logic [ADDR_W-1:0] al_aj [MONT_LAT];
    logic [ADDR_W-1:0] al_ak [MONT_LAT];

    logic              s1_v;
    coeff_t            s1_sum;
    coeff_t            s1_dif;
    logic [ADDR_W-1:0] s1_aj;
    logic [ADDR_W-1:0] s1_ak;

    // Free-running alignment line; its last slot meets mont_t.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MONT_LAT; i++) begin
                al_v[i]  <= 1'b0;
                al_r[i]  <= '0;
                al_aj[i] <= '0;
                al_ak[i] <= '0;
            end
        end else begin
            al_v[0]  <= bus.issue_valid;
            al_r[0]  <= bus.r_j;
            al_aj[0] <= bus.addr_j;
            al_ak[0] <= bus.addr_k;
            for (int unsigned i = 1; i < MONT_LAT; i++) begin
                al_v[i]  <= al_v[i-1];
                al_r[i]  <= al_r[i-1];
                al_aj[i] <= al_aj[i-1];
                al_ak[i] <= al_ak[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v   <= 1'b0;
            s1_sum <= '0;
            s1_dif <= '0;
            s1_aj  <= '0;
            s1_ak  <= '0;
        end else begin
            s1_v <= al_v[MONT_LAT-1];
            if (al_v[MONT_LAT-1]) begin
                s1_sum <= 16'(17'(al_r[MONT_LAT-1]) + 17'(bus.mont_t));
                s1_dif <= 16'(17'(al_r[MONT_LAT-1]) - 17'(bus.mont_t));
                s1_aj  <= al_aj[MONT_LAT-1];
                s1_ak  <= al_ak[MONT_LAT-1];
            end
        end
    end

    barrett_reduce #(.Q(KYBER_Q), .V(BARRETT_V)) u_red_lo (
        .clk (clk),
        .rst (rst),
        .en  (s1_v),
        .x   (s1_sum),
        .y   (bus.out_lo)
    );

    barrett_reduce #(.Q(KYBER_Q), .V(BARRETT_V)) u_red_hi (
        .clk (clk),
        .rst (rst),
        .en  (s1_v),
        .x   (s1_dif),
        .y   (bus.out_hi)
    );

    // Counter and layer_done load in the same stage as the reduced pair, so they line up with out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_addr_j <= '0;
            bus.out_addr_k <= '0;
            bus.bf_count   <= '0;
            bus.layer_done <= 1'b0;
        end else begin
            bus.out_valid  <= s1_v;
            bus.layer_done <= 1'b0;
            if (s1_v) begin
                bus.out_addr_j <= s1_aj;
                bus.out_addr_k <= s1_ak;
                if (bus.bf_count == 8'(BF_PER_LAYER - 1)) begin
                    bus.bf_count   <= '0;
                    bus.layer_done <= 1'b1;
                end else begin
                    bus.bf_count <= bus.bf_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_bf_post.sv
// Directed-plus-random bench for ntt_bf_post against a modular-arithmetic reference with cycle-indexed expectations.
module tb_ntt_bf_post;
    import kyber_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_bf_post_if #(.ADDR_W(8)) bus ();
    ntt_bf_post_if #(.ADDR_W(8)) bus3 ();

    ntt_bf_post #(.MONT_LAT(2), .ADDR_W(8), .BF_PER_LAYER(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ntt_bf_post #(.MONT_LAT(3), .ADDR_W(8), .BF_PER_LAYER(128)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       ev  [1024];
    int         elo [1024];
    int         ehi [1024];
    logic [7:0] eaj [1024];
    logic [7:0] eak [1024];
    int         tsch[1024];

    int         h_lo, h_hi, cnt;
    logic [7:0] h_aj, h_ak;
    logic       edone;

    // Centred residue of x modulo q, computed by plain division.
    function automatic int ref_mod(int x);
        int m;
        m = x % 3329;
        if (m < 0) m += 3329;
        if (m > 1664) m -= 3329;
        return m;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        if (ev[cyc]) begin
            h_lo  = elo[cyc];
            h_hi  = ehi[cyc];
            h_aj  = eaj[cyc];
            h_ak  = eak[cyc];
            cnt   = (cnt + 1) % 128;
            edone = (cnt == 0);
        end else begin
            edone = 1'b0;
        end
        chk("out_valid",  32'(bus.out_valid), 32'(ev[cyc]));
        chk("out_lo",     bus.out_lo, h_lo);
        chk("out_hi",     bus.out_hi, h_hi);
        chk("out_addr_j", 32'(bus.out_addr_j), 32'(h_aj));
        chk("out_addr_k", 32'(bus.out_addr_k), 32'(h_ak));
        chk("layer_done", 32'(bus.layer_done), 32'(edone));
        chk("bf_count",   32'(bus.bf_count), cnt);
    endtask

    // One clock: check outputs of this cycle, drive inputs sampled at its closing edge.
    task automatic tick(logic iv, int r, logic [7:0] aj, logic [7:0] ak, int t);
        check_cycle();
        bus.issue_valid = iv;
        bus.r_j         = 16'(r);
        bus.addr_j      = aj;
        bus.addr_k      = ak;
        bus.mont_t      = 16'(tsch[cyc]);
        if (iv) begin
            tsch[cyc+2] = t;
            ev[cyc+4]   = 1'b1;
            elo[cyc+4]  = ref_mod(r + t);
            ehi[cyc+4]  = ref_mod(r - t);
            eaj[cyc+4]  = aj;
            eak[cyc+4]  = ak;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.issue_valid = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_lo",    bus.out_lo, 0);
        chk("rst_hi",    bus.out_hi, 0);
        chk("rst_aj",    32'(bus.out_addr_j), 0);
        chk("rst_ak",    32'(bus.out_addr_k), 0);
        chk("rst_done",  32'(bus.layer_done), 0);
        chk("rst_count", 32'(bus.bf_count), 0);
        for (int i = cyc; i < 1024; i++) ev[i] = 1'b0;
        h_lo = 0; h_hi = 0; h_aj = '0; h_ak = '0; cnt = 0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r, t;
        for (int i = 0; i < 1024; i++) begin
            ev[i]   = 1'b0;
            tsch[i] = int'($urandom_range(65535));
        end
        h_lo = 0; h_hi = 0; h_aj = '0; h_ak = '0; cnt = 0; edone = 1'b0;
        bus.issue_valid = 1'b0; bus.r_j = '0; bus.addr_j = '0; bus.addr_k = '0; bus.mont_t = '0;
        bus3.issue_valid = 1'b0; bus3.r_j = '0; bus3.addr_j = '0; bus3.addr_k = '0; bus3.mont_t = '0;

        @(negedge clk);
        do_reset();

        // Directed values, including the reduction corner cases
        tick(1'b1, 100, 8'h10, 8'h90, 50);
        idle(5);
        chk("basic_lo", bus.out_lo, 150);
        chk("basic_hi", bus.out_hi, 50);
        chk("basic_aj", 32'(bus.out_addr_j), 32'h10);
        tick(1'b1, 3000, 8'h11, 8'h91, 1000);
        idle(5);
        chk("red_lo", bus.out_lo, 671);
        chk("red_hi", bus.out_hi, -1329);
        tick(1'b1, -5, 8'h12, 8'h92, 10);
        idle(5);
        chk("neg_lo", bus.out_lo, 5);
        chk("neg_hi", bus.out_hi, -15);

        // Bubbles 1,0,1,1,0
        tick(1'b1, 1200, 8'h20, 8'ha0, -700);
        tick(1'b0, 0, 8'h00, 8'h00, 0);
        tick(1'b1, -16383, 8'h21, 8'ha1, 16383);
        tick(1'b1, 16383, 8'h22, 8'ha2, 16383);
        tick(1'b0, 0, 8'h00, 8'h00, 0);
        idle(5);

        // Reset with three butterflies in flight, then a fresh one
        tick(1'b1, 11, 8'h30, 8'hb0, 22);
        tick(1'b1, 33, 8'h31, 8'hb1, 44);
        tick(1'b1, 55, 8'h32, 8'hb2, 66);
        do_reset();
        idle(6);
        tick(1'b1, 777, 8'h33, 8'hb3, -888);
        idle(5);
        chk("post_rst_count", 32'(bus.bf_count), 1);

        // Two back-to-back layers of random legal butterflies
        do_reset();
        for (int i = 0; i < 255; i++) begin
            r = int'($urandom_range(32766)) - 16383;
            t = int'($urandom_range(32766)) - 16383;
            tick(1'b1, r, 8'(i), 8'(i + 128), t);
        end
        idle(5);
        chk("layer2_count", 32'(bus.bf_count), 127);

        // MONT_LAT=3 instance: mont_t three cycles after issue, output five cycles after
        for (int j = 0; j < 7; j++) begin
            chk("lat3_valid", 32'(bus3.out_valid), (j == 5) ? 1 : 0);
            if (j == 5) begin
                chk("lat3_lo", bus3.out_lo, 150);
                chk("lat3_hi", bus3.out_hi, 50);
                chk("lat3_ak", 32'(bus3.out_addr_k), 32'h5a);
            end
            bus3.issue_valid = (j == 0);
            bus3.r_j         = 16'sd100;
            bus3.addr_j      = 8'h4a;
            bus3.addr_k      = 8'h5a;
            bus3.mont_t      = (j == 3) ? 16'sd50 : 16'h7abc;
            tick(1'b0, 0, 8'h00, 8'h00, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_bf_post.md
# ntt_bf_post

Butterfly post-processing stage for the Kyber NTT datapath, directly downstream of the Montgomery reduction pipeline. The NTT controller issues a butterfly by sending `zeta*r[j+len]` into the Montgomery reducer. At the same time it hands this block `r[j]` and the two write-back addresses. The block delays those side-band values to meet the reduced product `t`, computes `r[j]+t` and `r[j]-t`, Barrett-reduces both, and presents them with their addresses for write-back to coefficient RAM. It also counts butterflies and flags the end of each NTT layer.

## Interface
Parameters:
- `KYBER_Q`, 3329, modulus q
- `BARRETT_V`, 20159, `((1<<26)+q/2)/q`
- `MONT_LAT`, 2, cycles from product issue to valid `mont_t`; legal range 1..4
- `ADDR_W`, 8, coefficient address width
- `BF_PER_LAYER`, 128, butterflies per NTT layer

Ports:
- `clk` in 1, clock
- `rst` in 1, reset; asynchronous, active-high
- `issue_valid` in 1, product issued to the Montgomery reducer this cycle
- `r_j` in 16 signed, upper butterfly operand, sampled with `issue_valid`
- `addr_j` in ADDR_W, write address for the sum, sampled with `issue_valid`
- `addr_k` in ADDR_W, write address for the difference, sampled with `issue_valid`
- `mont_t` in 16 signed, Montgomery result; sampled exactly MONT_LAT cycles after the matching issue
- `out_valid` out 1, output pair valid
- `out_lo` out 16 signed, `barrett(r_j + t)`
- `out_hi` out 16 signed, `barrett(r_j - t)`
- `out_addr_j` out ADDR_W, write address for `out_lo`
- `out_addr_k` out ADDR_W, write address for `out_hi`
- `layer_done` out 1, one-cycle pulse with the BF_PER_LAYER-th `out_valid` of a layer
- `bf_count` out 8, butterflies emitted in the current layer

## Operation
- **Alignment line.** A MONT_LAT-deep shift register carries {valid, r_j, addr_j, addr_k}. It advances every cycle; there is no stall. Its tail lines up with `mont_t`.
- **Stage S1.** Registered when the tail is valid:
  - `sum = r_j + mont_t`
  - `dif = r_j - mont_t`
  - Both are computed 17-bit signed and then truncated to 16 bits.
  - Legal operands satisfy |r_j|, |mont_t| ≤ 16383, so truncation is lossless. Out-of-range operands give undefined numeric results, but valid and address tracking is unaffected.
- **Stage S2 (Barrett), applied to each of sum and dif:**
  - `q_est = (BARRETT_V*x + 2^25) >>> 26`, using an arithmetic shift and a 32-bit signed product.
  - `y = x - q_est*KYBER_Q`
  - The result lies in [-(q-1)/2, (q-1)/2] and is registered onto `out_lo` / `out_hi`.
- **Side-band data.** Addresses and valid travel unchanged alongside the data. Invalid slots do not update the data registers; those registers hold their last value.
- **Layer counter.**
  - `bf_count` increments on each `out_valid`.
  - When `out_valid` arrives with `bf_count == BF_PER_LAYER-1`, `layer_done` pulses and `bf_count` wraps to 0.
  - Back-to-back layers need no gap.
- **Reset.** Asynchronous. Clears every valid bit in the alignment line, S1 and S2; clears `bf_count`, `layer_done` and all data and address registers to 0.
- **Reset mid-operation.** All in-flight butterflies are dropped silently. `mont_t` values arriving after reset deasserts have no matching valid, so they are ignored.

## Timing
- Issue at cycle k gives `out_valid` at cycle k+MONT_LAT+2. With the default parameters that is k+4.
- Full throughput: one butterfly per cycle, sustained indefinitely.
- Gaps in `issue_valid` reappear as identical gaps in `out_valid`.
- `layer_done` is combinational-free: it is registered in S2 and coincident with the final `out_valid` of the layer.
- Reset values: all outputs are 0.

## Structure
- Shared package `kyber_pkg`: KYBER_Q, BARRETT_V, the MONT/QINV constants, and the coefficient type (16-bit signed).
- One sub-module, `barrett_reduce`: a single registered stage, instantiated twice (sum and dif).
- Alignment line, S1 and the counter are written inline.

## Test plan
- **Basic butterfly.** Issue r_j=100; two cycles later mont_t=50 → four cycles after issue: `out_lo`=150, `out_hi`=50, addresses echoed.
- **Reduction.** r_j=3000, t=1000 → `out_lo`=671, `out_hi`=-1329. r_j=-5, t=10 → `out_lo`=5, `out_hi`=-15.
- **Streaming.**
  - 128 consecutive issues with incrementing addr_j; random legal operands checked against a C-model of `barrett_reduce`.
  - One `out_valid` per cycle; `layer_done` asserts only on the 128th output, then `bf_count` reads 0.
  - A second layer immediately follows and counts 1..127 without a gap.
- **Bubbles.** Issue pattern 1,0,1,1,0 → `out_valid` pattern 1,0,1,1,0, delayed by 4 cycles; data in the bubble slots unchanged.
- **Reset mid-stream.**
  - Pulse `rst` for a cycle in which 3 butterflies are in flight → no `out_valid` appears afterwards, `bf_count`=0, all outputs 0.
  - A fresh issue after reset is processed normally.
- **MONT_LAT=3 build.** Repeat the basic butterfly with `mont_t` sampled 3 cycles after issue → output at k+5.
